uart_rx_sequencer: RTL and testbench
====================================

# uart_rx_sequencer

Controller for the UART receive path. It generates the 16x oversampling baud tick from an 8-bit divisor and runs the start/data/stop framing state machine from that tick. It assembles LSB-first 8N1 bytes and presents each byte through a valid/ack handshake with framing-error and overrun flags. It sits between the asynchronous `RXD` pin and the RX consumer, and replaces free-running baud counting with a sequenced, reloadable tick.

## Interface
- `OVERSAMPLE`, 16: ticks per bit; must be a power of 2, minimum 4.
- `DIV_W`, 8: divisor width.
- `CLK` in 1: sole clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `CE` in 1: block enable. When 0: tick counter held at `D`, FSM forced to IDLE, flags retained.
- `D` in `DIV_W`: baud divisor. Tick period is `D+1` CLK cycles.
- `RXD` in 1: asynchronous serial input, idle high.
- `ACK` in 1: consumer accepts `DOUT`.
- `DOUT` out 8: last good byte.
- `VALID` out 1: `DOUT` holds an unacknowledged byte.
- `FERR` out 1: one-cycle pulse when a stop bit is sampled low.
- `OVR` out 1: sticky; a byte completed while `VALID`=1. Cleared by `ACK`.
- `BUSY` out 1: FSM is not in IDLE.

## Operation
- **Synchronizer.** Two-flop synchronizer on `RXD`, reset value 1. The FSM sees only the synchronized `rx_s`.
- **Tick generator.**
  - Down-counter loads `D` at reset and whenever `CE`=0.
  - At 0 it asserts `tick` for one cycle and reloads `D`; otherwise it decrements.
  - `D`=0 gives a tick every cycle.
  - A change to `D` takes effect at the next reload only.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. `os_cnt` is log2(`OVERSAMPLE`) bits and `bit_cnt` is 3 bits; both advance on `tick` only.
  - IDLE: on tick with `rx_s`=0 → START, `os_cnt`=0.
  - START: on tick, `os_cnt`++. When `os_cnt`=`OVERSAMPLE/2-1` is reached:
    - `rx_s`=0 → DATA, `os_cnt`=0, `bit_cnt`=0.
    - `rx_s`=1 → IDLE (glitch rejected).
  - DATA: on tick with `os_cnt`=`OVERSAMPLE-1`, shift `rx_s` into `shreg` MSB (right-shift, so LSB first) and wrap `os_cnt`. When `bit_cnt`=7 → STOP; else `bit_cnt`++.
  - STOP: on tick with `os_cnt`=`OVERSAMPLE-1`:
    - `rx_s`=1 → `DOUT`<=`shreg`, `VALID`<=1, → IDLE.
    - `rx_s`=0 → `FERR` pulse, `DOUT` unchanged, → BREAK.
  - BREAK: stay until a tick with `rx_s`=1, then → IDLE. This prevents a held-low line from retriggering.
- **Handshake.**
  - `ACK` with `VALID`=1 clears `VALID` and `OVR` next cycle.
  - A byte completing while `VALID`=1 and no `ACK` sets `OVR` and overwrites `DOUT`.
  - Completion and `ACK` in the same cycle: new byte wins, `VALID` stays 1, `OVR` not set.
  - `ACK` with `VALID`=0 is ignored.
- **`CE` drop mid-frame.** Frame aborted, no `VALID` or `FERR`; `DOUT`/`VALID`/`OVR` retained.

## Timing
- Reset values: `DOUT`=0x00, `VALID`=0, `FERR`=0, `OVR`=0, `BUSY`=0, FSM IDLE, counter=`D`, sync flops=1.
- All outputs are registered.
- Bit period: `OVERSAMPLE`*(`D+1`) CLK.
- Sample point: mid-bit, ±1 tick of detection uncertainty plus 2 CLK of synchronizer delay.
- `VALID` rises about 9.5 bit periods after the `RXD` falling edge: the detect tick, then 8 ticks to mid-start, then 9×16 ticks.
- `FERR` is high for exactly one CLK.
- `BUSY` is registered from the next state and rises the cycle the FSM leaves IDLE.
- Reset mid-frame: all state returns to reset values asynchronously; the partial byte is discarded.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK).
  - `UART_OVERSAMPLE`=16 and `UART_DATA_BITS`=8 constants.
- Sub-module `uart_baud_tick`: reloadable down-counter with ports `CLK`, `RST_N`, `CE`, `D`, `TICK`. It is reused by the TX path.
- The FSM, shift register and handshake stay in the top level.

## Test plan
- `D`=3 (bit = 64 CLK), send 0xA5 8N1 → `DOUT`=0xA5, `VALID`=1 about 608 CLK after the start edge, `FERR`=0. `ACK` → `VALID`=0 next cycle.
- `RXD` low for 3 ticks (12 CLK), then high → START returns to IDLE, no `VALID`, `BUSY` back to 0.
- Send 0x3C with stop bit 0 → one-cycle `FERR`, `DOUT` unchanged, FSM in BREAK while `RXD` stays low. `RXD` high → IDLE, next frame 0x81 received correctly.
- Send 0x11 then 0x22 with no `ACK` → `DOUT`=0x22, `OVR`=1. Repeat with `ACK` in the completion cycle of 0x22 → `OVR`=0, `VALID`=1.
- Assert `RST_N`=0 mid DATA bit 4 → outputs take reset values immediately. After release, 0x5A is received cleanly.
- `D`=0, send 0xFF, then drop `CE` mid-frame → first byte valid (bit = 16 CLK), aborted frame yields no `VALID` or `FERR`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the RX sequencer and the TX path.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Consumer-side handshake bundle of the UART receiver: byte, valid/ack, status flags.
interface uart_rx_sequencer_if;

    logic [7:0] DOUT;
    logic       VALID;
    logic       ACK;
    logic       FERR;
    logic       OVR;
    logic       BUSY;

    modport master (output DOUT, VALID, FERR, OVR, BUSY, input ACK);
    modport slave  (input DOUT, VALID, FERR, OVR, BUSY, output ACK);

endinterface

// File: rtl/uart_baud_tick.sv
// Reloadable down-counter producing one oversampling tick every D+1 clocks.
module uart_baud_tick #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic [DIV_W-1:0] D,
    output logic             TICK
);

    logic [DIV_W-1:0] cnt;
    logic             primed;

    // Reset cannot load a port value, so the first enabled cycle does the load of D.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (!CE || !primed) begin
            cnt    <= D;
            primed <= 1'b1;
        end else if (cnt == '0) begin
            cnt <= D;
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign TICK = CE && primed && (cnt == '0);

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART 8N1 receive sequencer: RXD synchronizer, baud tick, framing FSM and valid/ack output.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DIV_W      = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CE,
    input  logic [DIV_W-1:0]     D,
    input  logic                 RXD,
    uart_rx_sequencer_if.master  rx
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [2:0]      BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic                      rx_meta;
    logic                      rx_s;
    logic                      tick;
    rx_state_t                 state;
    logic [OS_W-1:0]           os_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [7:0]                dout;
    logic                      valid;
    logic                      ferr;
    logic                      ovr;
    logic                      busy;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(.DIV_W(DIV_W)) baud (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CE    (CE),
        .D     (D),
        .TICK  (tick)
    );

    // Framing FSM; the handshake update comes first so a completing byte overrides an ACK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ferr <= 1'b0;
            if (rx.ACK && valid) begin
                valid <= 1'b0;
                ovr   <= 1'b0;
            end
            if (!CE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state  <= START;
                            os_cnt <= '0;
                            busy   <= 1'b1;
                        end
                    end
                    START: begin
                        if (os_cnt == OS_MID) begin
                            if (!rx_s) begin
                                state   <= DATA;
                                os_cnt  <= '0;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                    DATA: begin
                        os_cnt <= os_cnt + OS_W'(1);
                        if (os_cnt == OS_LAST) begin
                            shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        os_cnt <= os_cnt + OS_W'(1);
                        if (os_cnt == OS_LAST) begin
                            if (rx_s) begin
                                dout  <= shreg;
                                valid <= 1'b1;
                                if (valid && !rx.ACK) begin
                                    ovr <= 1'b1;
                                end
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                ferr  <= 1'b1;
                                state <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx.DOUT  = dout;
    assign rx.VALID = valid;
    assign rx.FERR  = ferr;
    assign rx.OVR   = ovr;
    assign rx.BUSY  = busy;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: frame-level expectation model plus per-cycle output comparison.
module tb_uart_rx_sequencer;

    localparam int OS = 16;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       CE;
    logic [7:0] D;
    logic       RXD;
    int         cyc = 0;

    int tests  = 0;
    int errors = 0;

    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_ovr;
    logic       m_ferr;
    logic       hold;
    int         ferr_seen;
    int         ferr_exp;

    uart_rx_sequencer_if rx_bus ();

    uart_rx_sequencer #(.OVERSAMPLE(OS), .DIV_W(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CE    (CE),
        .D     (D),
        .RXD   (RXD),
        .rx    (rx_bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic sampleGap();
        @(negedge CLK);
        #2;
    endtask

    // Per-cycle comparison against the model; suppressed only inside the completion-uncertainty window.
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (rx_bus.FERR === 1'b1) ferr_seen++;
            if (!hold) begin
                checkOutput("cmp_dout",  rx_bus.DOUT,  m_dout);
                checkOutput("cmp_valid", rx_bus.VALID, m_valid);
                checkOutput("cmp_ovr",   rx_bus.OVR,   m_ovr);
                checkOutput("cmp_ferr",  rx_bus.FERR,  m_ferr);
            end
        end
    end

    task automatic doAck();
        @(negedge CLK);
        rx_bus.ACK = 1'b1;
        @(negedge CLK);
        rx_bus.ACK = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    // mode 0: full frame; mode 1: CE dropped mid data bit 3; mode 2: reset mid data bit 4.
    // A frame completes 152 ticks after the detect tick; detection lands 3..3+D clocks after the edge.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int mode, input bit ack_at_done);
        int bit_len;
        int lo;
        int hi;
        int idx;
        int cut;
        bit_len = OS * (int'(D) + 1);
        lo      = 3 + (OS / 2 + 9 * OS) * (int'(D) + 1);
        hi      = lo + int'(D);
        cut     = bit_len * ((mode == 1) ? 4 : 5) + bit_len / 2;
        @(negedge CLK);
        for (int rel = 0; rel < 10 * bit_len; rel++) begin
            if (rel > 0) @(negedge CLK);
            idx = rel / bit_len;
            RXD = (idx == 0) ? 1'b0 : (idx <= 8) ? data[idx-1] : stop_bit;
            if (mode == 0) begin
                if (rel == bit_len * 5) checkOutput("busy_mid_frame", rx_bus.BUSY, 1);
                if (ack_at_done && rel == hi - 1) rx_bus.ACK = 1'b1;
                if (rel == lo && lo < hi) hold = 1'b1;
                if (rel == hi) begin
                    rx_bus.ACK = 1'b0;
                    if (stop_bit) begin
                        m_ovr   = ack_at_done ? 1'b0 : (m_ovr | m_valid);
                        m_valid = 1'b1;
                        m_dout  = data;
                        hold    = 1'b0;
                    end else begin
                        ferr_exp++;
                        if (lo == hi) m_ferr = 1'b1;
                    end
                end
                if (rel == hi + 1 && !stop_bit) begin
                    hold   = 1'b0;
                    m_ferr = 1'b0;
                end
            end else if (rel == cut) begin
                if (mode == 1) begin
                    CE = 1'b0;
                end else begin
                    RST_N   = 1'b0;
                    m_dout  = 8'h00;
                    m_valid = 1'b0;
                    m_ovr   = 1'b0;
                    m_ferr  = 1'b0;
                end
                RXD = 1'b1;
                break;
            end
        end
        if (mode == 0) checkOutput("busy_end_frame", rx_bus.BUSY, stop_bit ? 0 : 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_N = 1'b1; CE = 1'b1; D = 8'd3; RXD = 1'b1; rx_bus.ACK = 1'b0;
        hold = 1'b0; m_dout = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        ferr_seen = 0; ferr_exp = 0;
        #2 RST_N = 1'b0;
        repeat (3) sampleGap();
        checkOutput("reset_dout",  rx_bus.DOUT,  8'h00);
        checkOutput("reset_valid", rx_bus.VALID, 0);
        checkOutput("reset_ovr",   rx_bus.OVR,   0);
        checkOutput("reset_ferr",  rx_bus.FERR,  0);
        checkOutput("reset_busy",  rx_bus.BUSY,  0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);

        // 0xA5 at D=3, then acknowledge
        applyStimulus(8'hA5, 1'b1, 0, 1'b0);
        sampleGap();
        checkOutput("a5_dout",  rx_bus.DOUT,  8'hA5);
        checkOutput("a5_valid", rx_bus.VALID, 1);
        checkOutput("a5_nferr", ferr_seen,    0);
        doAck();
        sampleGap();
        checkOutput("a5_ack_valid", rx_bus.VALID, 0);

        // Start glitch of 12 clocks
        @(negedge CLK);
        RXD = 1'b0;
        repeat (12) @(negedge CLK);
        checkOutput("glitch_busy_hi", rx_bus.BUSY, 1);
        RXD = 1'b1;
        repeat (48) @(negedge CLK);
        checkOutput("glitch_busy_lo", rx_bus.BUSY, 0);
        checkOutput("glitch_valid",   rx_bus.VALID, 0);

        // Framing error followed by a held-low line, then recovery
        applyStimulus(8'h3C, 1'b0, 0, 1'b0);
        repeat (3 * 64) @(negedge CLK);
        checkOutput("break_busy", rx_bus.BUSY, 1);
        sampleGap();
        checkOutput("break_ferr_count", ferr_seen, ferr_exp);
        checkOutput("break_ferr_lit",   ferr_seen, 1);
        checkOutput("break_dout",       rx_bus.DOUT, 8'hA5);
        @(negedge CLK);
        RXD = 1'b1;
        repeat (2 * 64) @(negedge CLK);
        checkOutput("break_exit_busy", rx_bus.BUSY, 0);
        applyStimulus(8'h81, 1'b1, 0, 1'b0);
        sampleGap();
        checkOutput("after_break_dout", rx_bus.DOUT, 8'h81);

        // Overrun scenarios at D=0 where completion timing is exact
        doAck();
        D = 8'd0;
        repeat (10) @(negedge CLK);
        applyStimulus(8'h11, 1'b1, 0, 1'b0);
        applyStimulus(8'h22, 1'b1, 0, 1'b0);
        sampleGap();
        checkOutput("ovr_dout", rx_bus.DOUT, 8'h22);
        checkOutput("ovr_set",  rx_bus.OVR,  1);
        doAck();
        sampleGap();
        checkOutput("ovr_cleared", rx_bus.OVR, 0);
        applyStimulus(8'h11, 1'b1, 0, 1'b0);
        applyStimulus(8'h22, 1'b1, 0, 1'b1);
        sampleGap();
        checkOutput("ackdone_ovr",   rx_bus.OVR,   0);
        checkOutput("ackdone_valid", rx_bus.VALID, 1);
        checkOutput("ackdone_dout",  rx_bus.DOUT,  8'h22);

        // Reset in the middle of data bit 4, then a clean frame
        applyStimulus(8'h77, 1'b1, 2, 1'b0);
        #1;
        checkOutput("midrst_dout",  rx_bus.DOUT,  8'h00);
        checkOutput("midrst_valid", rx_bus.VALID, 0);
        checkOutput("midrst_ovr",   rx_bus.OVR,   0);
        checkOutput("midrst_busy",  rx_bus.BUSY,  0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        applyStimulus(8'h5A, 1'b1, 0, 1'b0);
        sampleGap();
        checkOutput("post_rst_dout",  rx_bus.DOUT,  8'h5A);
        checkOutput("post_rst_valid", rx_bus.VALID, 1);

        // 0xFF at 16-clock bits, then a frame aborted by CE
        doAck();
        applyStimulus(8'hFF, 1'b1, 0, 1'b0);
        sampleGap();
        checkOutput("ff_dout", rx_bus.DOUT, 8'hFF);
        applyStimulus(8'h00, 1'b1, 1, 1'b0);
        repeat (20) @(negedge CLK);
        CE = 1'b1;
        repeat (200) @(negedge CLK);
        sampleGap();
        checkOutput("abort_dout",  rx_bus.DOUT,  8'hFF);
        checkOutput("abort_valid", rx_bus.VALID, 1);
        checkOutput("abort_ovr",   rx_bus.OVR,   0);
        checkOutput("abort_busy",  rx_bus.BUSY,  0);
        checkOutput("abort_ferr_count", ferr_seen, ferr_exp);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
